// File: rtl/dmem_lsu.sv
// Handshaked load/store data memory: word array with byte-lane writes, LAT-cycle response.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of aligning them down.
module dmem_lsu #(
    parameter int ADDR_W = 9,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              we_q, err_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       mem_q [DEPTH];

    logic              accept, is_half, is_word, f3_illegal, misalign, req_err, wr_en;
    logic [ADDR_W-1:0] eff_addr;
    logic [3:0]        be;
    logic [31:0]       wdata_rep, rd_word, rd_shift, load_ext, load_data;

    assign accept  = req_valid && (state_q == IDLE);
    assign is_half = (req_funct3[1:0] == 2'b01);
    assign is_word = (req_funct3[1:0] == 2'b10);
    assign f3_illegal = req_we ? (req_funct3 >= 3'b011)
                               : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    assign eff_addr = req_addr;
`else
    assign misalign = 1'b0;
    always_comb begin
        eff_addr = req_addr;
        if (is_word)
            eff_addr[1:0] = 2'b00;
        else if (is_half)
            eff_addr[0] = 1'b0;
    end
`endif

    assign req_err = f3_illegal || misalign;
    assign wr_en   = accept && req_we && !req_err;

    // Replicated store data lines up with whichever lane the enable selects.
    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << eff_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << eff_addr[1:0];
                wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = req_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (be[b])
                    mem_q[eff_addr[ADDR_W-1:2]][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
    end

    assign rd_word  = mem_q[addr_q[ADDR_W-1:2]];
    assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  load_ext = {24'b0, rd_shift[7:0]};
            3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  load_ext = {16'b0, rd_shift[15:0]};
            default: load_ext = rd_shift;
        endcase
    end

    assign load_data = (we_q || err_q) ? 32'b0 : load_ext;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = 2'(LAT - 1);
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d   = RESP;
                    rdata_d   = load_data;
                    rsp_err_d = err_q;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d   = IDLE;
                    rdata_d   = 32'b0;
                    rsp_err_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            rdata_q   <= 32'b0;
            rsp_err_q <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            f3_q      <= 3'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rsp_err_q <= rsp_err_d;
            if (accept) begin
                we_q   <= req_we;
                err_q  <= req_err;
                f3_q   <= req_funct3;
                addr_q <= eff_addr;
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu at LAT=3; misalignment checks follow DMEM_MISALIGN_TRAP_EN.
module tb_dmem_lsu;
    localparam int ADDR_W = 9;
    localparam int LAT    = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_ready, req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid, rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;
    logic        er;
    int          lat;

    dmem_lsu #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // One full transaction with rsp_ready high; lat counts edges from accept to rsp_valid.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = 32'b0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'b0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b rd=%h err=%b want 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_aligned_word();
        xact(1'b1, 3'b010, 9'h010, 32'hDEADBEEF);
        checks++;
        if (er !== 1'b0 || rd !== 32'b0 || lat !== LAT) begin
            errors++;
            $display("FAIL sw_aligned got err=%b rd=%h lat=%0d want 0 0 %0d", er, rd, lat, LAT);
        end
        xact(1'b0, 3'b010, 9'h010, 32'h0);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== LAT) begin
            errors++;
            $display("FAIL lw_aligned got rd=%h err=%b lat=%0d want deadbeef 0 %0d", rd, er, lat, LAT);
        end
    endtask

    task automatic test_byte_lanes();
        xact(1'b1, 3'b000, 9'h013, 32'h0000007F);
        xact(1'b0, 3'b010, 9'h010, 32'h0);
        checks++;
        if (rd !== 32'h7FADBEEF) begin
            errors++;
            $display("FAIL sb_merge got %h want 7fadbeef", rd);
        end
        xact(1'b0, 3'b000, 9'h011, 32'h0);
        checks++;
        if (rd !== 32'hFFFFFFBE || er !== 1'b0) begin
            errors++;
            $display("FAIL lb_sign got %h err=%b want ffffffbe 0", rd, er);
        end
        xact(1'b0, 3'b100, 9'h011, 32'h0);
        checks++;
        if (rd !== 32'h000000BE) begin
            errors++;
            $display("FAIL lbu_zero got %h want 000000be", rd);
        end
        xact(1'b0, 3'b000, 9'h012, 32'h0);
        checks++;
        if (rd !== 32'hFFFFFFAD) begin
            errors++;
            $display("FAIL lb_lane2 got %h want ffffffad", rd);
        end
    endtask

    task automatic test_halfwords();
        xact(1'b1, 3'b010, 9'h020, 32'h11223344);
        xact(1'b1, 3'b001, 9'h022, 32'hFFFF8001);
        xact(1'b0, 3'b001, 9'h022, 32'h0);
        checks++;
        if (rd !== 32'hFFFF8001) begin
            errors++;
            $display("FAIL lh_sign got %h want ffff8001", rd);
        end
        xact(1'b0, 3'b101, 9'h022, 32'h0);
        checks++;
        if (rd !== 32'h00008001) begin
            errors++;
            $display("FAIL lhu_zero got %h want 00008001", rd);
        end
        xact(1'b0, 3'b010, 9'h020, 32'h0);
        checks++;
        if (rd !== 32'h80013344) begin
            errors++;
            $display("FAIL sh_merge got %h want 80013344", rd);
        end
    endtask

    task automatic test_illegal_funct3();
        xact(1'b0, 3'b011, 9'h010, 32'h0);
        checks++;
        if (er !== 1'b1 || rd !== 32'b0) begin
            errors++;
            $display("FAIL ld_f3_011 got err=%b rd=%h want 1 0", er, rd);
        end
        xact(1'b0, 3'b110, 9'h010, 32'h0);
        checks++;
        if (er !== 1'b1 || rd !== 32'b0) begin
            errors++;
            $display("FAIL ld_f3_110 got err=%b rd=%h want 1 0", er, rd);
        end
        xact(1'b1, 3'b100, 9'h010, 32'h00000000);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL st_f3_100 got err=%b want 1", er);
        end
        xact(1'b0, 3'b010, 9'h010, 32'h0);
        checks++;
        if (rd !== 32'h7FADBEEF) begin
            errors++;
            $display("FAIL st_illegal_nowrite got %h want 7fadbeef", rd);
        end
    endtask

    task automatic test_misalign();
`ifdef DMEM_MISALIGN_TRAP_EN
        xact(1'b1, 3'b010, 9'h011, 32'hAAAAAAAA);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL sw_misalign got err=%b want 1", er);
        end
        xact(1'b0, 3'b010, 9'h010, 32'h0);
        checks++;
        if (rd !== 32'h7FADBEEF) begin
            errors++;
            $display("FAIL sw_misalign_nowrite got %h want 7fadbeef", rd);
        end
        xact(1'b0, 3'b001, 9'h021, 32'h0);
        checks++;
        if (er !== 1'b1 || rd !== 32'b0) begin
            errors++;
            $display("FAIL lh_misalign got err=%b rd=%h want 1 0", er, rd);
        end
`else
        xact(1'b0, 3'b010, 9'h013, 32'h0);
        checks++;
        if (er !== 1'b0 || rd !== 32'h7FADBEEF) begin
            errors++;
            $display("FAIL lw_align_down got err=%b rd=%h want 0 7fadbeef", er, rd);
        end
        xact(1'b0, 3'b001, 9'h021, 32'h0);
        checks++;
        if (er !== 1'b0 || rd !== 32'h00003344) begin
            errors++;
            $display("FAIL lh_align_down got err=%b rd=%h want 0 00003344", er, rd);
        end
`endif
    endtask

    task automatic test_backpressure();
        int w;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 9'h010;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        w = 0;
        while (!rsp_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        // Competing store to the same word must be ignored while busy.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
            req_addr = 9'h010; req_wdata = 32'h12345678;
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h7FADBEEF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got vld=%b rd=%h err=%b rdy=%b want 1 7fadbeef 0 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
        end
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
        end
        xact(1'b0, 3'b010, 9'h010, 32'h0);
        checks++;
        if (rd !== 32'h7FADBEEF) begin
            errors++;
            $display("FAIL bp_ignored_store got %h want 7fadbeef", rd);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 9'h040; req_wdata = 32'hCAFEF00D; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'b0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got vld=%b rdy=%b rd=%h err=%b want 0 1 0 0",
                     rsp_valid, req_ready, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_drop got %0d response cycles want 0", seen);
        end
        xact(1'b0, 3'b010, 9'h040, 32'h0);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            errors++;
            $display("FAIL reset_store_kept got %h err=%b want cafef00d 0", rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_aligned_word();
        test_byte_lanes();
        test_halfwords();
        test_illegal_funct3();
        test_misalign();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
